// File: rtl/axi4_pkg.sv
// AXI4 field widths and per-channel payload widths shared by the slice and its interfaces.
package axi4;

  localparam int AXI4_BURST_W = 2;
  localparam int AXI4_CACHE_W = 4;
  localparam int AXI4_LEN_W   = 8;
  localparam int AXI4_LOCK_W  = 1;
  localparam int AXI4_PROT_W  = 3;
  localparam int AXI4_QOS_W   = 4;
  localparam int AXI4_SIZE_W  = 3;
  localparam int AXI4_RESP_W  = 2;

  function automatic int axi4_ar_payload_width(input int addr_w, input int user_w, input int id_w);
    return id_w + addr_w + AXI4_LEN_W + AXI4_SIZE_W + AXI4_BURST_W + AXI4_LOCK_W
         + AXI4_CACHE_W + AXI4_PROT_W + AXI4_QOS_W + user_w;
  endfunction

  function automatic int axi4_aw_payload_width(input int addr_w, input int user_w, input int id_w);
    return axi4_ar_payload_width(addr_w, user_w, id_w);
  endfunction

  function automatic int axi4_w_payload_width(input int data_w);
    return data_w + data_w / 8 + 1;
  endfunction

  function automatic int axi4_r_payload_width(input int data_w, input int id_w);
    return id_w + data_w + AXI4_RESP_W + 1;
  endfunction

  function automatic int axi4_b_payload_width(input int id_w);
    return id_w + AXI4_RESP_W;
  endfunction

endpackage

// File: rtl/axi4_intf.sv
// AXI4 channel interfaces; "in" is the receiving side of a channel, "out" the sending side.
interface axi4_ar_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  import axi4::*;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [AXI4_LEN_W-1:0]   arlen;
  logic [AXI4_SIZE_W-1:0]  arsize;
  logic [AXI4_BURST_W-1:0] arburst;
  logic [AXI4_LOCK_W-1:0]  arlock;
  logic [AXI4_CACHE_W-1:0] arcache;
  logic [AXI4_PROT_W-1:0]  arprot;
  logic [AXI4_QOS_W-1:0]   arqos;
  logic [USER_WIDTH-1:0]   aruser;
  logic                    arvalid;
  logic                    arready;
  modport in  (input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
               output arready);
  modport out (output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
               input  arready);
endinterface

interface axi4_aw_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  import axi4::*;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [AXI4_LEN_W-1:0]   awlen;
  logic [AXI4_SIZE_W-1:0]  awsize;
  logic [AXI4_BURST_W-1:0] awburst;
  logic [AXI4_LOCK_W-1:0]  awlock;
  logic [AXI4_CACHE_W-1:0] awcache;
  logic [AXI4_PROT_W-1:0]  awprot;
  logic [AXI4_QOS_W-1:0]   awqos;
  logic [USER_WIDTH-1:0]   awuser;
  logic                    awvalid;
  logic                    awready;
  modport in  (input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
               output awready);
  modport out (output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
               input  awready);
endinterface

interface axi4_w_intf #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  modport in  (input  wdata, wstrb, wlast, wvalid, output wready);
  modport out (output wdata, wstrb, wlast, wvalid, input  wready);
endinterface

interface axi4_r_intf #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  import axi4::*;
  logic [ID_WIDTH-1:0]    rid;
  logic [DATA_WIDTH-1:0]  rdata;
  logic [AXI4_RESP_W-1:0] rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;
  modport in  (input  rid, rdata, rresp, rlast, rvalid, output rready);
  modport out (output rid, rdata, rresp, rlast, rvalid, input  rready);
endinterface

interface axi4_b_intf #(
  parameter int ID_WIDTH = 1
);
  import axi4::*;
  logic [ID_WIDTH-1:0]    bid;
  logic [AXI4_RESP_W-1:0] bresp;
  logic                   bvalid;
  logic                   bready;
  modport in  (input  bid, bresp, bvalid, output bready);
  modport out (output bid, bresp, bvalid, input  bready);
endinterface

// File: rtl/axi4_slice_stage.sv
// Valid/ready buffer: DEPTH 0 = wire, 1 = half-rate register, >=2 = circular FIFO; 1-cycle latency when buffered.
// Backpressure: in_rdy is derived from registered state only, so ready never chains combinationally.
module axi4_slice_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             empty
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_vld = in_vld;
    assign in_rdy  = out_rdy;
    assign out_dat = in_dat;
    assign empty   = 1'b1;
  end else if (DEPTH == 1) begin : g_reg
    logic             full;
    logic [WIDTH-1:0] data;
    assign in_rdy  = !full;
    assign out_vld = full;
    assign out_dat = data;
    assign empty   = !full;

    // Push and pop can never coincide: a full register refuses new beats.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  full <= 1'b0;
      else if (in_vld && !full)  full <= 1'b1;
      else if (out_rdy && full)  full <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (in_vld && !full) data <= in_dat;
    end
  end else begin : g_fifo
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    assign in_rdy  = (count != FULL_CNT);
    assign out_vld = (count != '0);
    assign empty   = (count == '0);
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_dat;
    end
  end

endmodule

// File: rtl/axi4_slice.sv
// Five-channel AXI4 buffer, each channel independently a wire, half-rate register or FIFO; payloads opaque.
// Buffered channels add one cycle of latency and push back upstream only from registered state.
module axi4_slice
  import axi4::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int AR_DEPTH   = 2,
  parameter int AW_DEPTH   = 2,
  parameter int W_DEPTH    = 2,
  parameter int R_DEPTH    = 2,
  parameter int B_DEPTH    = 2
) (
  input  logic      clk,
  input  logic      rst,
  axi4_ar_intf.in   s_ar,
  axi4_aw_intf.in   s_aw,
  axi4_w_intf.in    s_w,
  axi4_r_intf.out   s_r,
  axi4_b_intf.out   s_b,
  axi4_ar_intf.out  m_ar,
  axi4_aw_intf.out  m_aw,
  axi4_w_intf.out   m_w,
  axi4_r_intf.in    m_r,
  axi4_b_intf.in    m_b,
  output logic      idle
);

  localparam int AR_W = axi4_ar_payload_width(ADDR_WIDTH, USER_WIDTH, ID_WIDTH);
  localparam int AW_W = axi4_aw_payload_width(ADDR_WIDTH, USER_WIDTH, ID_WIDTH);
  localparam int W_W  = axi4_w_payload_width(DATA_WIDTH);
  localparam int R_W  = axi4_r_payload_width(DATA_WIDTH, ID_WIDTH);
  localparam int B_W  = axi4_b_payload_width(ID_WIDTH);

  logic [AR_W-1:0] ar_in, ar_out;
  logic [AW_W-1:0] aw_in, aw_out;
  logic [W_W-1:0]  w_in,  w_out;
  logic [R_W-1:0]  r_in,  r_out;
  logic [B_W-1:0]  b_in,  b_out;
  logic            ar_empty, aw_empty, w_empty, r_empty, b_empty;

  assign ar_in = {s_ar.arid, s_ar.araddr, s_ar.arlen, s_ar.arsize, s_ar.arburst,
                  s_ar.arlock, s_ar.arcache, s_ar.arprot, s_ar.arqos, s_ar.aruser};
  assign {m_ar.arid, m_ar.araddr, m_ar.arlen, m_ar.arsize, m_ar.arburst,
          m_ar.arlock, m_ar.arcache, m_ar.arprot, m_ar.arqos, m_ar.aruser} = ar_out;

  assign aw_in = {s_aw.awid, s_aw.awaddr, s_aw.awlen, s_aw.awsize, s_aw.awburst,
                  s_aw.awlock, s_aw.awcache, s_aw.awprot, s_aw.awqos, s_aw.awuser};
  assign {m_aw.awid, m_aw.awaddr, m_aw.awlen, m_aw.awsize, m_aw.awburst,
          m_aw.awlock, m_aw.awcache, m_aw.awprot, m_aw.awqos, m_aw.awuser} = aw_out;

  assign w_in = {s_w.wdata, s_w.wstrb, s_w.wlast};
  assign {m_w.wdata, m_w.wstrb, m_w.wlast} = w_out;

  // R and B flow back from the subordinate towards the manager.
  assign r_in = {m_r.rid, m_r.rdata, m_r.rresp, m_r.rlast};
  assign {s_r.rid, s_r.rdata, s_r.rresp, s_r.rlast} = r_out;

  assign b_in = {m_b.bid, m_b.bresp};
  assign {s_b.bid, s_b.bresp} = b_out;

  axi4_slice_stage #(.WIDTH(AR_W), .DEPTH(AR_DEPTH)) u_ar (
    .clk(clk), .rst(rst),
    .in_vld(s_ar.arvalid), .in_rdy(s_ar.arready), .in_dat(ar_in),
    .out_vld(m_ar.arvalid), .out_rdy(m_ar.arready), .out_dat(ar_out), .empty(ar_empty));

  axi4_slice_stage #(.WIDTH(AW_W), .DEPTH(AW_DEPTH)) u_aw (
    .clk(clk), .rst(rst),
    .in_vld(s_aw.awvalid), .in_rdy(s_aw.awready), .in_dat(aw_in),
    .out_vld(m_aw.awvalid), .out_rdy(m_aw.awready), .out_dat(aw_out), .empty(aw_empty));

  axi4_slice_stage #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w (
    .clk(clk), .rst(rst),
    .in_vld(s_w.wvalid), .in_rdy(s_w.wready), .in_dat(w_in),
    .out_vld(m_w.wvalid), .out_rdy(m_w.wready), .out_dat(w_out), .empty(w_empty));

  axi4_slice_stage #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r (
    .clk(clk), .rst(rst),
    .in_vld(m_r.rvalid), .in_rdy(m_r.rready), .in_dat(r_in),
    .out_vld(s_r.rvalid), .out_rdy(s_r.rready), .out_dat(r_out), .empty(r_empty));

  axi4_slice_stage #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b (
    .clk(clk), .rst(rst),
    .in_vld(m_b.bvalid), .in_rdy(m_b.bready), .in_dat(b_in),
    .out_vld(s_b.bvalid), .out_rdy(s_b.bready), .out_dat(b_out), .empty(b_empty));

  assign idle = ar_empty && aw_empty && w_empty && r_empty && b_empty;

endmodule

// File: tb/tb_axi4_slice.sv
// Directed bench for axi4_slice with AR=2, AW=3, W=2, R=1 (half-rate) and B=0 (wire).
module tb_axi4_slice;

  logic clk = 1'b0;
  logic rst;
  logic idle;
  int   n_chk  = 0;
  int   n_pass = 0;

  axi4_ar_intf s_ar();
  axi4_aw_intf s_aw();
  axi4_w_intf  s_w();
  axi4_r_intf  s_r();
  axi4_b_intf  s_b();
  axi4_ar_intf m_ar();
  axi4_aw_intf m_aw();
  axi4_w_intf  m_w();
  axi4_r_intf  m_r();
  axi4_b_intf  m_b();

  axi4_slice #(
    .AR_DEPTH(2), .AW_DEPTH(3), .W_DEPTH(2), .R_DEPTH(1), .B_DEPTH(0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_ar(s_ar), .s_aw(s_aw), .s_w(s_w), .s_r(s_r), .s_b(s_b),
    .m_ar(m_ar), .m_aw(m_aw), .m_w(m_w), .m_r(m_r), .m_b(m_b),
    .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] q[$];
  logic [63:0] aw_exp;
  int sent, rcvd, cyc_n;
  bit acc;

  initial begin
    rst = 1'b0;
    {s_ar.arid, s_ar.araddr, s_ar.arlen, s_ar.arsize, s_ar.arburst, s_ar.arlock,
     s_ar.arcache, s_ar.arprot, s_ar.arqos, s_ar.aruser, s_ar.arvalid} = '0;
    {s_aw.awid, s_aw.awaddr, s_aw.awlen, s_aw.awsize, s_aw.awburst, s_aw.awlock,
     s_aw.awcache, s_aw.awprot, s_aw.awqos, s_aw.awuser, s_aw.awvalid} = '0;
    {s_w.wdata, s_w.wstrb, s_w.wlast, s_w.wvalid} = '0;
    {m_r.rid, m_r.rdata, m_r.rresp, m_r.rlast, m_r.rvalid} = '0;
    {m_b.bid, m_b.bresp, m_b.bvalid} = '0;
    m_ar.arready = 1'b0; m_aw.awready = 1'b0; m_w.wready = 1'b0;
    s_r.rready = 1'b0;   s_b.bready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_idle", idle, 1);
    chk("rst_valids", {m_ar.arvalid, m_aw.awvalid, m_w.wvalid, s_r.rvalid}, 0);
    #2 rst = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_ready", {s_ar.arready, s_aw.awready, s_w.wready, m_r.rready}, 4'hF);
    tick();

    // W: 16 back-to-back beats through the 2-deep FIFO
    m_w.wready = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      s_w.wvalid = (i < 16);
      s_w.wdata  = 32'(i);
      s_w.wstrb  = 4'hF;
      s_w.wlast  = (i == 15);
      @(negedge clk);
      if (i < 16) chk("w_in_ready", s_w.wready, 1);
      if (i >= 1 && i <= 16)
        chk("w_beat", {m_w.wvalid, m_w.wdata, m_w.wstrb, m_w.wlast},
            {1'b1, 32'(i - 1), 4'hF, 1'(i == 16)});
      else
        chk("w_no_beat", m_w.wvalid, 0);
      tick();
    end
    s_w.wvalid = 1'b0;
    m_w.wready = 1'b0;

    // AR: fill 2-deep FIFO, third beat held upstream, then drain in order
    s_ar.arvalid = 1'b1;
    s_ar.araddr  = 32'h100;
    @(negedge clk);
    chk("ar_rdy0", s_ar.arready, 1);
    chk("ar_out0", m_ar.arvalid, 0);
    tick();
    s_ar.araddr = 32'h200;
    @(negedge clk);
    chk("ar_rdy1", s_ar.arready, 1);
    chk("ar_head1", {m_ar.arvalid, m_ar.araddr}, {1'b1, 32'h100});
    tick();
    s_ar.araddr = 32'h300;
    @(negedge clk);
    chk("ar_full", s_ar.arready, 0);
    chk("ar_head2", {m_ar.arvalid, m_ar.araddr}, {1'b1, 32'h100});
    tick();
    @(negedge clk);
    chk("ar_full_hold", s_ar.arready, 0);
    tick();
    m_ar.arready = 1'b1;
    @(negedge clk);
    chk("ar_drain0", {m_ar.arvalid, m_ar.araddr}, {1'b1, 32'h100});
    chk("ar_full_reg", s_ar.arready, 0);
    tick();
    @(negedge clk);
    chk("ar_drain1", {m_ar.arvalid, m_ar.araddr}, {1'b1, 32'h200});
    chk("ar_rdy_again", s_ar.arready, 1);
    tick();
    s_ar.arvalid = 1'b0;
    @(negedge clk);
    chk("ar_drain2", {m_ar.arvalid, m_ar.araddr}, {1'b1, 32'h300});
    tick();
    @(negedge clk);
    chk("ar_empty", m_ar.arvalid, 0);
    tick();
    m_ar.arready = 1'b0;

    // R: half-rate register, one beat every two cycles
    m_r.rvalid = 1'b1;
    s_r.rready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      m_r.rdata = 32'((c + 1) / 2);
      m_r.rlast = 1'(((c + 1) / 2) % 2);
      @(negedge clk);
      chk("r_in_ready", m_r.rready, 1'(c % 2 == 0));
      if (c % 2 == 1)
        chk("r_beat", {s_r.rvalid, s_r.rdata, s_r.rlast}, {1'b1, 32'(c / 2), 1'((c / 2) % 2)});
      else
        chk("r_bubble", s_r.rvalid, 0);
      tick();
    end
    m_r.rvalid = 1'b0;
    @(negedge clk);
    chk("r_drained", s_r.rvalid, 0);
    s_r.rready = 1'b0;
    #1;
    chk("r_no_comb_ready", m_r.rready, 1);
    tick();

    // B: wire mode, zero latency in both directions
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      m_b.bvalid = k[0];
      s_b.bready = k[1];
      m_b.bid    = k[1];
      m_b.bresp  = 2'(k);
      #1;
      chk("b_valid", s_b.bvalid, k[0]);
      chk("b_ready", m_b.bready, k[1]);
      chk("b_payload", {s_b.bid, s_b.bresp}, {k[1], 2'(k)});
    end
    m_b.bvalid = 1'b0;
    s_b.bready = 1'b0;
    tick();

    // AW: 3-deep FIFO under random valid/ready, scoreboard-checked
    sent = 0; rcvd = 0; cyc_n = 0;
    while (rcvd < 1000 && cyc_n < 8000) begin
      if (!s_aw.awvalid && sent < 1000 && $urandom_range(1) == 1) begin
        s_aw.awaddr = $urandom;
        {s_aw.awid, s_aw.awlen, s_aw.awsize, s_aw.awburst, s_aw.awlock,
         s_aw.awcache, s_aw.awprot, s_aw.awqos, s_aw.awuser} = 27'($urandom);
        s_aw.awvalid = 1'b1;
      end
      m_aw.awready = 1'($urandom_range(1));
      @(negedge clk);
      chk("aw_idle", idle, 1'(q.size() == 0));
      chk("aw_flags", {s_aw.awready, m_aw.awvalid}, {1'(q.size() != 3), 1'(q.size() != 0)});
      if (m_aw.awvalid && m_aw.awready && q.size() > 0) begin
        aw_exp = q.pop_front();
        chk("aw_beat", {m_aw.awid, m_aw.awaddr, m_aw.awlen, m_aw.awsize, m_aw.awburst,
                        m_aw.awlock, m_aw.awcache, m_aw.awprot, m_aw.awqos, m_aw.awuser}, aw_exp);
        rcvd++;
      end
      acc = 1'b0;
      if (s_aw.awvalid && s_aw.awready) begin
        q.push_back({s_aw.awid, s_aw.awaddr, s_aw.awlen, s_aw.awsize, s_aw.awburst,
                     s_aw.awlock, s_aw.awcache, s_aw.awprot, s_aw.awqos, s_aw.awuser});
        sent++;
        acc = 1'b1;
      end
      tick();
      if (acc) s_aw.awvalid = 1'b0;
      cyc_n++;
    end
    chk("aw_received", rcvd, 1000);
    chk("aw_leftover", q.size(), 0);
    m_aw.awready = 1'b0;

    // Mid-stream reset: buffers hold beats, reset must drop them at once
    s_ar.arvalid = 1'b1; s_ar.araddr = 32'hDEAD_0000;
    s_aw.awvalid = 1'b1; s_aw.awaddr = 32'hBEEF_0000;
    s_w.wvalid   = 1'b1; s_w.wdata   = 32'h0000_0BAD;
    m_r.rvalid   = 1'b1; m_r.rdata   = 32'h0000_0DEF;
    tick();
    tick();
    @(negedge clk);
    chk("pre_rst_busy", {idle, m_ar.arvalid, m_w.wvalid, s_r.rvalid}, 4'b0111);
    rst = 1'b0;
    #1;
    chk("mid_rst_valids", {m_ar.arvalid, m_aw.awvalid, m_w.wvalid, s_r.rvalid, s_b.bvalid}, 0);
    chk("mid_rst_idle", idle, 1);
    s_ar.arvalid = 1'b0; s_aw.awvalid = 1'b0; s_w.wvalid = 1'b0; m_r.rvalid = 1'b0;
    tick();
    rst = 1'b1;
    m_ar.arready = 1'b1; m_aw.awready = 1'b1; m_w.wready = 1'b1; s_r.rready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_arready", s_ar.arready, 1);
      chk("no_stale_beat", {m_ar.arvalid, m_aw.awvalid, m_w.wvalid, s_r.rvalid}, 0);
      chk("post_rst_idle", idle, 1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
